// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and encodings for the multi-cycle control sequencer
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_U = 2'b11;

    localparam int STATUS_Z = 0;
    localparam int STATUS_N = 1;
    localparam int STATUS_C = 2;
    localparam int STATUS_V = 3;

    // funct7[5] selects SUB only for register ops; for immediates it only matters on shifts
    function automatic logic [3:0] funct3_aluop(input logic [2:0] f3, input logic f7_5,
                                                input logic is_r);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = f7_5 ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_seq_if.sv
// rtl/multicycle_seq_if.sv - request/ready handshake between sequencer and memory
interface multicycle_seq_if;
    logic mem_req;
    logic memrw;
    logic mem_ready;

    modport master (output mem_req, output memrw, input mem_ready);
    modport slave  (input mem_req, input memrw, output mem_ready);
endinterface

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - opcode/funct decode into ALU controls and legality
module alu_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_aluop,
    output logic       o_alusrc,
    output logic [1:0] o_immgen,
    output logic       o_illegal
);

    always_comb begin
        o_aluop   = ALU_ADD;
        o_alusrc  = 1'b0;
        o_immgen  = IMM_I;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_R:      o_aluop = funct3_aluop(i_funct3, i_funct7_5, 1'b1);
            OP_IALU: begin
                o_aluop  = funct3_aluop(i_funct3, i_funct7_5, 1'b0);
                o_alusrc = 1'b1;
            end
            OP_LOAD:   o_alusrc = 1'b1;
            OP_STORE: begin
                o_alusrc = 1'b1;
                o_immgen = IMM_S;
            end
            OP_BRANCH: begin
                o_aluop  = ALU_SUB;
                o_immgen = IMM_B;
            end
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_seq.sv
// rtl/multicycle_seq.sv - FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath controls
module multicycle_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned RETIRE_W    = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic [4:0]           status,
    multicycle_seq_if.master     mem,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 pcsrc,
    output logic                 alusrc,
    output logic [3:0]           aluop,
    output logic [1:0]           immgen_ctrl,
    output logic                 regrw,
    output logic                 wb,
    output logic                 trap,
    output logic [RETIRE_W-1:0]  retired
);

    state_t              r_state, w_state_nxt;
    logic [31:0]         r_wait;
    logic [RETIRE_W-1:0] r_retired;
    logic [3:0]          r_aluop;
    logic                r_alusrc;
    logic [1:0]          r_immgen;

    logic [3:0] w_dec_aluop;
    logic       w_dec_alusrc, w_dec_illegal;
    logic [1:0] w_dec_immgen;
    logic       w_is_load, w_is_store, w_is_branch, w_taken, w_timeout;
    logic       w_ir_we, w_pc_we, w_pcsrc, w_retire, w_mem_req, w_memrw, w_regrw, w_wb, w_trap;
    logic       w_hold;
    logic       w_unused;

    alu_decode u_alu_decode (
        .i_opcode   (instr[6:0]),
        .i_funct3   (instr[14:12]),
        .i_funct7_5 (instr[30]),
        .o_aluop    (w_dec_aluop),
        .o_alusrc   (w_dec_alusrc),
        .o_immgen   (w_dec_immgen),
        .o_illegal  (w_dec_illegal)
    );

    assign w_is_load   = (instr[6:0] == OP_LOAD);
    assign w_is_store  = (instr[6:0] == OP_STORE);
    assign w_is_branch = (instr[6:0] == OP_BRANCH);
    assign w_taken     = ((instr[14:12] == 3'b000) &&  status[STATUS_Z]) ||
                         ((instr[14:12] == 3'b001) && !status[STATUS_Z]);
    // r_wait counts completed wait cycles, so this is the MEM_TIMEOUT-th cycle without ready
    assign w_timeout   = (MEM_TIMEOUT != 0) && (r_wait == MEM_TIMEOUT - 1);
    assign w_unused    = &{1'b0, instr[31], instr[29:15], instr[11:7], status[4:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pcsrc     = 1'b0;
        w_retire    = 1'b0;
        w_mem_req   = 1'b0;
        w_memrw     = 1'b0;
        w_regrw     = 1'b0;
        w_wb        = 1'b0;
        w_trap      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (mem.mem_ready) begin
                    w_ir_we     = 1'b1;
                    w_state_nxt = ST_DECODE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_TRAP;
                end
            end
            ST_DECODE: w_state_nxt = w_dec_illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                if (w_is_branch) begin
                    w_pc_we     = 1'b1;
                    w_pcsrc     = w_taken;
                    w_retire    = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                w_mem_req = 1'b1;
                w_memrw   = w_is_store;
                if (mem.mem_ready) begin
                    if (w_is_store) begin
                        w_pc_we     = 1'b1;
                        w_retire    = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_WB;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_TRAP;
                end
            end
            ST_WB: begin
                w_regrw     = 1'b1;
                w_wb        = w_is_load;
                w_pc_we     = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            ST_TRAP:  w_trap = 1'b1;
            default:  w_state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_FETCH;
            r_wait    <= '0;
            r_retired <= '0;
            r_aluop   <= ALU_ADD;
            r_alusrc  <= 1'b0;
            r_immgen  <= IMM_I;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= (w_state_nxt != r_state) ? 32'd0 : r_wait + 32'd1;
            if (w_retire)
                r_retired <= r_retired + 1'b1;
            if (r_state == ST_EXEC) begin
                r_aluop  <= w_dec_aluop;
                r_alusrc <= w_dec_alusrc;
                r_immgen <= w_dec_immgen;
            end
        end
    end

    assign w_hold = (r_state == ST_MEM) || (r_state == ST_WB);

    // Reset state is FETCH, so every decoded output is gated to keep it quiet while rst is low
    assign mem.mem_req = rst & w_mem_req;
    assign mem.memrw   = rst & w_memrw;
    assign ir_we       = rst & w_ir_we;
    assign pc_we       = rst & w_pc_we;
    assign pcsrc       = rst & w_pcsrc;
    assign regrw       = rst & w_regrw;
    assign wb          = rst & w_wb;
    assign trap        = rst & w_trap;
    assign aluop       = !rst ? 4'd0 : (r_state == ST_EXEC) ? w_dec_aluop  : w_hold ? r_aluop  : 4'd0;
    assign alusrc      = !rst ? 1'b0 : (r_state == ST_EXEC) ? w_dec_alusrc : w_hold ? r_alusrc : 1'b0;
    assign immgen_ctrl = !rst ? 2'd0 : (r_state == ST_EXEC) ? w_dec_immgen : w_hold ? r_immgen : 2'd0;
    assign retired     = r_retired;

endmodule

// File: tb/tb_multicycle_seq.sv
// tb/tb_multicycle_seq.sv - directed self-checking bench for multicycle_seq
module tb_multicycle_seq;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [4:0]  status;
    logic        ir_we, pc_we, pcsrc, alusrc, regrw, wb, trap;
    logic [3:0]  aluop;
    logic [1:0]  immgen_ctrl;
    logic [31:0] retired;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_ret;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_ADDI = 32'h40008193;
    localparam logic [31:0] I_SRAI = 32'h4020D193;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    multicycle_seq_if mem_bus ();

    multicycle_seq #(.RETIRE_W(32), .MEM_TIMEOUT(255)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .status      (status),
        .mem         (mem_bus),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pcsrc       (pcsrc),
        .alusrc      (alusrc),
        .aluop       (aluop),
        .immgen_ctrl (immgen_ctrl),
        .regrw       (regrw),
        .wb          (wb),
        .trap        (trap),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] ins, input int waits);
        instr = ins;
        for (int i = 0; i < waits; i++) begin
            mem_bus.mem_ready = 1'b0;
            #1;
            chk("fetch_wait_req", mem_bus.mem_req, 1);
            chk("fetch_wait_ir_we", ir_we, 0);
            step();
        end
        mem_bus.mem_ready = 1'b1;
        #1;
        chk("fetch_ir_we", ir_we, 1);
        chk("fetch_memrw", mem_bus.memrw, 0);
        step();
        mem_bus.mem_ready = 1'b0;
    endtask

    task automatic alu_instr(input string tag, input logic [31:0] ins, input logic [3:0] eop,
                             input logic esrc, input int waits);
        fetch(ins, waits);
        #1;
        chk({tag, "_dec_req"}, mem_bus.mem_req, 0);
        step();
        #1;
        chk({tag, "_aluop"}, aluop, eop);
        chk({tag, "_alusrc"}, alusrc, esrc);
        chk({tag, "_exec_pc_we"}, pc_we, 0);
        step();
        #1;
        chk({tag, "_regrw"}, regrw, 1);
        chk({tag, "_wb"}, wb, 0);
        chk({tag, "_wb_pc_we"}, pc_we, 1);
        chk({tag, "_wb_pcsrc"}, pcsrc, 0);
        chk({tag, "_aluop_held"}, aluop, eop);
        step();
        exp_ret++;
        #1;
        chk({tag, "_retired"}, retired, exp_ret);
    endtask

    task automatic branch(input string tag, input logic [31:0] ins, input logic [4:0] st,
                          input logic taken);
        status = st;
        fetch(ins, 0);
        step();
        #1;
        chk({tag, "_pc_we"}, pc_we, 1);
        chk({tag, "_pcsrc"}, pcsrc, taken);
        chk({tag, "_aluop"}, aluop, ALU_SUB);
        chk({tag, "_imm"}, immgen_ctrl, IMM_B);
        chk({tag, "_alusrc"}, alusrc, 0);
        step();
        exp_ret++;
        #1;
        chk({tag, "_retired"}, retired, exp_ret);
        chk({tag, "_refetch"}, mem_bus.mem_req, 1);
        status = 5'd0;
    endtask

    initial begin
        rst = 1'b0;
        instr = 32'd0;
        status = 5'd0;
        mem_bus.mem_ready = 1'b1;
        exp_ret = 32'd0;
        step();
        step();
        #1;
        chk("rst_mem_req", mem_bus.mem_req, 0);
        chk("rst_ir_we", ir_we, 0);
        chk("rst_retired", retired, 0);
        chk("rst_trap", trap, 0);

        mem_bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("fetch0_req", mem_bus.mem_req, 1);
        chk("fetch0_memrw", mem_bus.memrw, 0);

        alu_instr("add", I_ADD, ALU_ADD, 1'b0, 0);
        alu_instr("sub", I_SUB, ALU_SUB, 1'b0, 0);
        alu_instr("addi_f7", I_ADDI, ALU_ADD, 1'b1, 0);
        alu_instr("srai", I_SRAI, ALU_SRA, 1'b1, 0);

        fetch(I_LW, 3);
        step();
        #1;
        chk("lw_aluop", aluop, ALU_ADD);
        chk("lw_alusrc", alusrc, 1);
        chk("lw_imm", immgen_ctrl, IMM_I);
        chk("lw_exec_req", mem_bus.mem_req, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            mem_bus.mem_ready = 1'b0;
            #1;
            chk("lw_mem_req", mem_bus.mem_req, 1);
            chk("lw_mem_rd", mem_bus.memrw, 0);
            chk("lw_mem_alusrc_held", alusrc, 1);
            step();
        end
        mem_bus.mem_ready = 1'b1;
        #1;
        chk("lw_ready_pc_we", pc_we, 0);
        chk("lw_ready_regrw", regrw, 0);
        step();
        mem_bus.mem_ready = 1'b0;
        #1;
        chk("lw_regrw", regrw, 1);
        chk("lw_wb", wb, 1);
        chk("lw_pc_we", pc_we, 1);
        chk("lw_wb_req", mem_bus.mem_req, 0);
        step();
        exp_ret++;
        #1;
        chk("lw_retired", retired, exp_ret);

        fetch(I_SW, 0);
        step();
        #1;
        chk("sw_imm_exec", immgen_ctrl, IMM_S);
        chk("sw_alusrc", alusrc, 1);
        step();
        mem_bus.mem_ready = 1'b0;
        #1;
        chk("sw_mem_req", mem_bus.mem_req, 1);
        chk("sw_memrw", mem_bus.memrw, 1);
        chk("sw_imm_mem", immgen_ctrl, IMM_S);
        chk("sw_wait_pc_we", pc_we, 0);
        chk("sw_wait_regrw", regrw, 0);
        step();
        mem_bus.mem_ready = 1'b1;
        #1;
        chk("sw_ready_pc_we", pc_we, 1);
        chk("sw_ready_pcsrc", pcsrc, 0);
        chk("sw_ready_regrw", regrw, 0);
        step();
        mem_bus.mem_ready = 1'b0;
        exp_ret++;
        #1;
        chk("sw_retired", retired, exp_ret);
        chk("sw_next_memrw", mem_bus.memrw, 0);

        branch("beq_taken", I_BEQ, 5'b00001, 1'b1);
        branch("beq_not", I_BEQ, 5'b00000, 1'b0);
        branch("bne_taken", I_BNE, 5'b00000, 1'b1);
        branch("beq_nzc", I_BEQ, 5'b11110, 1'b0);

        fetch(I_ILL, 0);
        #1;
        chk("ill_decode_trap", trap, 0);
        step();
        #1;
        chk("ill_trap", trap, 1);
        chk("ill_req", mem_bus.mem_req, 0);
        for (int i = 0; i < 20; i++) begin
            mem_bus.mem_ready = 1'b1;
            step();
            #1;
            chk("ill_hold_trap", trap, 1);
            chk("ill_hold_req", mem_bus.mem_req, 0);
            chk("ill_hold_ir_we", ir_we, 0);
            chk("ill_hold_pc_we", pc_we, 0);
        end
        chk("ill_retired", retired, exp_ret);
        rst = 1'b0;
        #1;
        chk("ill_rst_trap", trap, 0);
        chk("ill_rst_retired", retired, 0);
        exp_ret = 32'd0;
        step();
        mem_bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("ill_restart_req", mem_bus.mem_req, 1);

        alu_instr("pre_rst_add", I_ADD, ALU_ADD, 1'b0, 0);
        fetch(I_LW, 0);
        step();
        step();
        #1;
        chk("midmem_req", mem_bus.mem_req, 1);
        rst = 1'b0;
        #1;
        chk("midmem_rst_req", mem_bus.mem_req, 0);
        chk("midmem_rst_retired", retired, 0);
        exp_ret = 32'd0;
        step();
        rst = 1'b1;
        #1;
        chk("midmem_restart_req", mem_bus.mem_req, 1);
        chk("midmem_restart_memrw", mem_bus.memrw, 0);
        alu_instr("post_rst_add", I_ADD, ALU_ADD, 1'b0, 0);

        alu_instr("late_add", I_ADD, ALU_ADD, 1'b0, 254);
        instr = I_ADD;
        mem_bus.mem_ready = 1'b0;
        for (int i = 0; i < 254; i++) step();
        #1;
        chk("to_last_wait_trap", trap, 0);
        chk("to_last_wait_req", mem_bus.mem_req, 1);
        step();
        #1;
        chk("to_trap", trap, 1);
        chk("to_req", mem_bus.mem_req, 0);
        chk("to_retired", retired, exp_ret);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
